// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if
// Request/response bundle between the datapath (master) and the data-memory
// responder (slave).
//   req_valid/req_write/req_addr/req_wdata : request from master
//   req_ready                              : responder can accept this cycle
//   rsp_valid/rsp_rdata/rsp_err            : one-cycle response pulse
//   busy                                   : transaction in flight
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_write;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder
// Responder end of the 16-bit data-memory port. One word read or write per
// request, WAIT_STATES extra cycles between accept and response, then a
// one-cycle response pulse carrying read data and an error flag.
//
// Parameters:
//   DEPTH_WORDS : words stored (power of two, 2..32768)
//   WAIT_STATES : extra cycles between accept and response (0..7)
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : data_mem_responder_if.slave (request, response, busy)
// Optional feature:
//   DMEM_ALIGN_CHECK_EN : when defined, odd byte addresses complete with
//                         rsp_err=1 and no write; otherwise bit 0 is ignored.
//
// State table:
//   ST_IDLE | no transaction, ready to accept
//   ST_WAIT | request latched, counting wait states
//   ST_RESP | response pulse cycle, may accept the next request
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 1
) (
    input logic                  clk,
    input logic                  rst_n,
    data_mem_responder_if.slave  bus
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [2:0] WAIT_LOAD = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t      state;
    logic [2:0]  wait_cnt;

    logic        lat_write;
    logic [14:0] lat_idx;
    logic [15:0] lat_wdata;
    logic        lat_odd;

    logic [15:0] mem [DEPTH_WORDS];

    logic        accept;
    logic        commit_en;
    logic        commit_write;
    logic [14:0] commit_idx;
    logic [15:0] commit_wdata;
    logic        commit_odd;
    logic        commit_err;
    logic        range_err;
    logic [AW-1:0] mem_idx;

    assign bus.req_ready = (state == ST_IDLE) || (state == ST_RESP);
    assign bus.busy      = (state == ST_WAIT) || (state == ST_RESP);
    assign accept        = bus.req_valid && bus.req_ready;

    // The commit source is the latched request when leaving WAIT, or the
    // incoming request directly when there are no wait states.
    always_comb begin
        commit_en    = 1'b0;
        commit_write = bus.req_write;
        commit_idx   = bus.req_addr[15:1];
        commit_wdata = bus.req_wdata;
        commit_odd   = bus.req_addr[0];
        if (state == ST_WAIT) begin
            commit_en    = (wait_cnt == 3'd0);
            commit_write = lat_write;
            commit_idx   = lat_idx;
            commit_wdata = lat_wdata;
            commit_odd   = lat_odd;
        end else begin
            commit_en    = accept && (WAIT_STATES == 0);
        end
    end

    assign range_err = {17'd0, commit_idx} >= 32'(DEPTH_WORDS);
    assign mem_idx   = commit_idx[AW-1:0];

`ifdef DMEM_ALIGN_CHECK_EN
    assign commit_err = range_err | commit_odd;
`else
    // Odd addresses alias the even word below them.
    logic unused_commit_odd;
    assign unused_commit_odd = commit_odd;
    assign commit_err = range_err;
`endif

    // Memory has no reset; contents survive rst_n.
    always_ff @(posedge clk) begin
        if (commit_en && commit_write && !commit_err) begin
            mem[mem_idx] <= commit_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            wait_cnt  <= 3'd0;
            lat_write <= 1'b0;
            lat_idx   <= 15'd0;
            lat_wdata <= 16'd0;
            lat_odd   <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= 16'd0;
        end else begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;

            case (state)
                ST_IDLE, ST_RESP: begin
                    if (accept) begin
                        lat_write <= bus.req_write;
                        lat_idx   <= bus.req_addr[15:1];
                        lat_wdata <= bus.req_wdata;
                        lat_odd   <= bus.req_addr[0];
                        if (WAIT_STATES == 0) begin
                            state <= ST_RESP;
                        end else begin
                            state    <= ST_WAIT;
                            wait_cnt <= WAIT_LOAD;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == 3'd0) begin
                        state <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            // Response registers update on the edge that enters RESP.
            if (commit_en) begin
                bus.rsp_valid <= 1'b1;
                bus.rsp_err   <= commit_err;
                if (commit_err) begin
                    bus.rsp_rdata <= 16'd0;
                end else if (!commit_write) begin
                    bus.rsp_rdata <= mem[mem_idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    data_mem_responder_if bus1 ();
    data_mem_responder_if bus0 ();
    data_mem_responder_if bus3 ();

    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(1)) u_ws1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave));
    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0.slave));
    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3.slave));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        exp_err;
        logic        chk_rdata;
        logic [15:0] exp_rdata;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Issues one request on the WAIT_STATES=1 instance; called at posedge+1
    // with the responder ready. lat counts cycles after the accept edge,
    // the cycle right after the edge being 1.
    task automatic txn1(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                        output logic err, output logic [15:0] rdata, output int lat,
                        output logic got);
        bus1.req_valid = 1'b1;
        bus1.req_write = wr;
        bus1.req_addr  = addr;
        bus1.req_wdata = wdata;
        @(posedge clk); #1;
        bus1.req_valid = 1'b0;
        lat = 1;
        got = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (bus1.rsp_valid) begin
                got = 1'b1;
                break;
            end
            @(posedge clk); #1;
            lat++;
        end
        err   = bus1.rsp_err;
        rdata = bus1.rsp_rdata;
    endtask

    initial begin
        logic        err;
        logic [15:0] rdata;
        int          lat;
        logic        got;

        vecs[0]  = '{1'b1, 16'h0010, 16'hBEEF, 1'b0, 1'b0, 16'h0000};
        vecs[1]  = '{1'b0, 16'h0010, 16'h0000, 1'b0, 1'b1, 16'hBEEF};
        vecs[2]  = '{1'b1, 16'h0000, 16'h1111, 1'b0, 1'b0, 16'h0000};
        vecs[3]  = '{1'b1, 16'h0200, 16'hAAAA, 1'b1, 1'b1, 16'h0000};
        vecs[4]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h1111};
        vecs[5]  = '{1'b0, 16'h0200, 16'h0000, 1'b1, 1'b1, 16'h0000};
        vecs[6]  = '{1'b1, 16'h01FE, 16'h7E7E, 1'b0, 1'b0, 16'h0000};
        vecs[7]  = '{1'b0, 16'h01FE, 16'h0000, 1'b0, 1'b1, 16'h7E7E};
        vecs[8]  = '{1'b1, 16'h0020, 16'h1357, 1'b0, 1'b0, 16'h0000};
        vecs[9]  = '{1'b0, 16'h0020, 16'h0000, 1'b0, 1'b1, 16'h1357};
`ifdef DMEM_ALIGN_CHECK_EN
        vecs[10] = '{1'b0, 16'h0011, 16'h0000, 1'b1, 1'b1, 16'h0000};
`else
        vecs[10] = '{1'b0, 16'h0011, 16'h0000, 1'b0, 1'b1, 16'hBEEF};
`endif
        vecs[11] = '{1'b1, 16'hFFFE, 16'hDEAD, 1'b1, 1'b1, 16'h0000};
        vecs[12] = '{1'b0, 16'h0010, 16'h0000, 1'b0, 1'b1, 16'hBEEF};

        bus1.req_valid = 1'b0; bus1.req_write = 1'b0; bus1.req_addr = '0; bus1.req_wdata = '0;
        bus0.req_valid = 1'b0; bus0.req_write = 1'b0; bus0.req_addr = '0; bus0.req_wdata = '0;
        bus3.req_valid = 1'b0; bus3.req_write = 1'b0; bus3.req_addr = '0; bus3.req_wdata = '0;

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_rsp_valid", 32'(bus1.rsp_valid), 32'd0);
        check("reset_rsp_rdata", 32'(bus1.rsp_rdata), 32'd0);
        check("reset_rsp_err",   32'(bus1.rsp_err),   32'd0);
        check("reset_busy",      32'(bus1.busy),      32'd0);
        check("reset_req_ready", 32'(bus1.req_ready), 32'd1);
        check("reset_ready_ws3", 32'(bus3.req_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table-driven single transactions on WAIT_STATES=1.
        for (int i = 0; i < NVEC; i++) begin
            txn1(vecs[i].wr, vecs[i].addr, vecs[i].wdata, err, rdata, lat, got);
            check($sformatf("vec%0d_got_rsp", i), 32'(got), 32'd1);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
            check($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
            if (vecs[i].chk_rdata) begin
                check($sformatf("vec%0d_rdata", i), 32'(rdata), 32'(vecs[i].exp_rdata));
            end
            @(posedge clk); #1;
            check($sformatf("vec%0d_pulse_end", i), 32'(bus1.rsp_valid), 32'd0);
            check($sformatf("vec%0d_err_low", i), 32'(bus1.rsp_err), 32'd0);
        end

        // Reset during WAIT of a write: dropped, no response.
        bus1.req_valid = 1'b1;
        bus1.req_write = 1'b1;
        bus1.req_addr  = 16'h0020;
        bus1.req_wdata = 16'h5555;
        @(posedge clk); #1;
        bus1.req_valid = 1'b0;
        check("rst_mid_busy_before", 32'(bus1.busy), 32'd1);
        check("rst_mid_ready_wait",  32'(bus1.req_ready), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_busy_async",  32'(bus1.busy), 32'd0);
        check("rst_mid_ready_async", 32'(bus1.req_ready), 32'd1);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check($sformatf("rst_mid_no_rsp%0d", c), 32'(bus1.rsp_valid), 32'd0);
        end
        txn1(1'b0, 16'h0020, 16'h0000, err, rdata, lat, got);
        check("rst_mid_read_got",   32'(got), 32'd1);
        check("rst_mid_read_old",   32'(rdata), 32'h1357);
        check("rst_mid_read_err",   32'(err), 32'd0);
        @(posedge clk); #1;

        // WAIT_STATES=0: back-to-back accept in RESP.
        bus0.req_valid = 1'b1;
        bus0.req_write = 1'b1;
        bus0.req_addr  = 16'h0004;
        bus0.req_wdata = 16'h1234;
        @(posedge clk); #1;
        check("ws0_b0_valid", 32'(bus0.rsp_valid), 32'd1);
        check("ws0_b0_err",   32'(bus0.rsp_err),   32'd0);
        check("ws0_b0_ready", 32'(bus0.req_ready), 32'd1);
        bus0.req_write = 1'b0;
        @(posedge clk); #1;
        check("ws0_b1_valid", 32'(bus0.rsp_valid), 32'd1);
        check("ws0_b1_rdata", 32'(bus0.rsp_rdata), 32'h1234);
        check("ws0_b1_err",   32'(bus0.rsp_err),   32'd0);
        bus0.req_write = 1'b1;
        bus0.req_addr  = 16'h0200;
        bus0.req_wdata = 16'hAAAA;
        @(posedge clk); #1;
        check("ws0_b2_valid", 32'(bus0.rsp_valid), 32'd1);
        check("ws0_b2_err",   32'(bus0.rsp_err),   32'd1);
        check("ws0_b2_rdata", 32'(bus0.rsp_rdata), 32'd0);
        bus0.req_write = 1'b0;
        bus0.req_addr  = 16'h0004;
        @(posedge clk); #1;
        check("ws0_b3_valid", 32'(bus0.rsp_valid), 32'd1);
        check("ws0_b3_rdata", 32'(bus0.rsp_rdata), 32'h1234);
        check("ws0_b3_err",   32'(bus0.rsp_err),   32'd0);
        bus0.req_valid = 1'b0;
        @(posedge clk); #1;
        check("ws0_end_valid", 32'(bus0.rsp_valid), 32'd0);
        check("ws0_end_busy",  32'(bus0.busy),      32'd0);

        // WAIT_STATES=3: request held during WAIT waits for RESP.
        bus3.req_valid = 1'b1;
        bus3.req_write = 1'b1;
        bus3.req_addr  = 16'h0006;
        bus3.req_wdata = 16'h4242;
        @(posedge clk); #1;
        bus3.req_write = 1'b0;
        check("ws3_c1_ready", 32'(bus3.req_ready), 32'd0);
        check("ws3_c1_valid", 32'(bus3.rsp_valid), 32'd0);
        check("ws3_c1_busy",  32'(bus3.busy),      32'd1);
        for (int c = 2; c <= 3; c++) begin
            @(posedge clk); #1;
            check($sformatf("ws3_c%0d_ready", c), 32'(bus3.req_ready), 32'd0);
            check($sformatf("ws3_c%0d_valid", c), 32'(bus3.rsp_valid), 32'd0);
        end
        @(posedge clk); #1;
        check("ws3_c4_valid", 32'(bus3.rsp_valid), 32'd1);
        check("ws3_c4_err",   32'(bus3.rsp_err),   32'd0);
        check("ws3_c4_ready", 32'(bus3.req_ready), 32'd1);
        @(posedge clk); #1;
        bus3.req_valid = 1'b0;
        check("ws3_rd_c1_ready", 32'(bus3.req_ready), 32'd0);
        check("ws3_rd_c1_valid", 32'(bus3.rsp_valid), 32'd0);
        lat = 1;
        got = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (bus3.rsp_valid) begin
                got = 1'b1;
                break;
            end
            @(posedge clk); #1;
            lat++;
        end
        check("ws3_rd_got",     32'(got), 32'd1);
        check("ws3_rd_latency", 32'(lat), 32'd4);
        check("ws3_rd_rdata",   32'(bus3.rsp_rdata), 32'h4242);
        check("ws3_rd_err",     32'(bus3.rsp_err), 32'd0);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
